// File: rtl/writeback_collector.sv
// Writeback collector: per-source result FIFOs feeding one round-robin register-file write per cycle.
// Optional WRITEBACK_ZERO_REG_DISCARD_EN: grants to R0 release the tag but suppress the write strobe.
module writeback_collector #(
  parameter int DATABITWIDTH    = 16,
  parameter int TAGBITWIDTH     = 6,
  parameter int REGADDRBITWIDTH = 4,
  parameter int FIFODEPTH       = 2
) (
  input  logic                         clk,
  input  logic                         sync_rst,
  input  logic                         clk_en,
  input  logic [3:0]                   SrcValid,
  output logic [3:0]                   SrcReady,
  input  logic [4*DATABITWIDTH-1:0]    SrcData,
  input  logic [4*REGADDRBITWIDTH-1:0] SrcRegAddr,
  input  logic [4*TAGBITWIDTH-1:0]     SrcTag,
  output logic                         RegWriteEn,
  output logic [REGADDRBITWIDTH-1:0]   RegWriteAddr,
  output logic [DATABITWIDTH-1:0]      RegWriteData,
  output logic                         TagReleaseValid,
  output logic [TAGBITWIDTH-1:0]       TagReleaseOut,
  output logic [1:0]                   WritebackSourceOut,
  output logic                         WritebackCongestionStallOut
);

  localparam int PTRW = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
  localparam int CNTW = $clog2(FIFODEPTH + 1);

  typedef struct packed {
    logic [TAGBITWIDTH-1:0]     tag;
    logic [REGADDRBITWIDTH-1:0] addr;
    logic [DATABITWIDTH-1:0]    data;
  } entry_t;

  entry_t            mem_q [4][FIFODEPTH];
  entry_t            src_entry [4];
  logic [PTRW-1:0]   rd_ptr_q [4], rd_ptr_d [4];
  logic [PTRW-1:0]   wr_ptr_q [4], wr_ptr_d [4];
  logic [CNTW-1:0]   count_q [4], count_d [4];
  logic [3:0]        push, pop, head_valid;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              grant;
  logic [1:0]        grant_idx;
  entry_t            head;

  logic                       reg_we_q, reg_we_d;
  logic [REGADDRBITWIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [DATABITWIDTH-1:0]    reg_data_q, reg_data_d;
  logic                       tag_valid_q, tag_valid_d;
  logic [TAGBITWIDTH-1:0]     tag_q, tag_d;
  logic [1:0]                 src_q, src_d;
  logic                       stall_q, stall_d;

  function automatic logic [PTRW-1:0] wrap_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(FIFODEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      src_entry[i].data = SrcData[i*DATABITWIDTH +: DATABITWIDTH];
      src_entry[i].addr = SrcRegAddr[i*REGADDRBITWIDTH +: REGADDRBITWIDTH];
      src_entry[i].tag  = SrcTag[i*TAGBITWIDTH +: TAGBITWIDTH];
      SrcReady[i]       = clk_en & (count_q[i] != CNTW'(FIFODEPTH));
      push[i]           = SrcValid[i] & SrcReady[i];
      head_valid[i]     = (count_q[i] != '0);
    end
  end

  // Search upward from the slot after the last winner; k = 4 revisits the last winner itself.
  always_comb begin
    grant     = 1'b0;
    grant_idx = rr_ptr_q;
    for (int k = 1; k <= 4; k++) begin
      if (!grant && head_valid[rr_ptr_q + 2'(k)]) begin
        grant     = 1'b1;
        grant_idx = rr_ptr_q + 2'(k);
      end
    end
    head = mem_q[grant_idx][rd_ptr_q[grant_idx]];
  end

  // NOTE: every always_comb output gets a default before any condition, so no path infers a latch.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    reg_we_d    = reg_we_q;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    tag_valid_d = tag_valid_q;
    tag_d       = tag_q;
    src_d       = src_q;
    stall_d     = stall_q;
    for (int i = 0; i < 4; i++) begin
      pop[i]      = clk_en & grant & (grant_idx == 2'(i));
      rd_ptr_d[i] = pop[i]  ? wrap_inc(rd_ptr_q[i]) : rd_ptr_q[i];
      wr_ptr_d[i] = push[i] ? wrap_inc(wr_ptr_q[i]) : wr_ptr_q[i];
      count_d[i]  = count_q[i];
      if (push[i] && !pop[i]) begin
        count_d[i] = count_q[i] + 1'b1;
      end else if (pop[i] && !push[i]) begin
        count_d[i] = count_q[i] - 1'b1;
      end
    end
    if (clk_en) begin
`ifdef WRITEBACK_ZERO_REG_DISCARD_EN
      reg_we_d    = grant & (head.addr != '0);
`else
      reg_we_d    = grant;
`endif
      tag_valid_d = grant;
      if (grant) begin
        rr_ptr_d   = grant_idx;
        reg_addr_d = head.addr;
        reg_data_d = head.data;
        tag_d      = head.tag;
        src_d      = grant_idx;
      end
      stall_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (count_d[i] >= CNTW'(FIFODEPTH - 1)) stall_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge sync_rst) begin
    if (sync_rst) begin
      for (int i = 0; i < 4; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_ptr_q    <= 2'd3;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      tag_valid_q <= 1'b0;
      tag_q       <= '0;
      src_q       <= '0;
      stall_q     <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      rr_ptr_q    <= rr_ptr_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      tag_valid_q <= tag_valid_d;
      tag_q       <= tag_d;
      src_q       <= src_d;
      stall_q     <= stall_d;
    end
  end

  // NOTE: FIFO storage has no reset; the counts alone decide which slots hold live data.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= src_entry[i];
    end
  end

  assign RegWriteEn                  = reg_we_q;
  assign RegWriteAddr                = reg_addr_q;
  assign RegWriteData                = reg_data_q;
  assign TagReleaseValid             = tag_valid_q;
  assign TagReleaseOut               = tag_q;
  assign WritebackSourceOut          = src_q;
  assign WritebackCongestionStallOut = stall_q;

endmodule

// File: tb/tb_writeback_collector.sv
// Self-checking bench for writeback_collector: per-cycle vector table plus a release scoreboard.
module tb_writeback_collector;
  localparam int DW = 16;
  localparam int TW = 6;
  localparam int AW = 4;
`ifdef WRITEBACK_ZERO_REG_DISCARD_EN
  localparam bit DISCARD = 1'b1;
`else
  localparam bit DISCARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          sync_rst;
  logic          clk_en;
  logic [3:0]    SrcValid;
  logic [3:0]    SrcReady;
  logic [DW-1:0] data_v [4];
  logic [AW-1:0] addr_v [4];
  logic [TW-1:0] tag_v [4];
  logic          RegWriteEn;
  logic [AW-1:0] RegWriteAddr;
  logic [DW-1:0] RegWriteData;
  logic          TagReleaseValid;
  logic [TW-1:0] TagReleaseOut;
  logic [1:0]    WritebackSourceOut;
  logic          WritebackCongestionStallOut;

  writeback_collector #(
    .DATABITWIDTH(DW), .TAGBITWIDTH(TW), .REGADDRBITWIDTH(AW), .FIFODEPTH(2)
  ) dut (
    .clk                         (clk),
    .sync_rst                    (sync_rst),
    .clk_en                      (clk_en),
    .SrcValid                    (SrcValid),
    .SrcReady                    (SrcReady),
    .SrcData                     ({data_v[3], data_v[2], data_v[1], data_v[0]}),
    .SrcRegAddr                  ({addr_v[3], addr_v[2], addr_v[1], addr_v[0]}),
    .SrcTag                      ({tag_v[3], tag_v[2], tag_v[1], tag_v[0]}),
    .RegWriteEn                  (RegWriteEn),
    .RegWriteAddr                (RegWriteAddr),
    .RegWriteData                (RegWriteData),
    .TagReleaseValid             (TagReleaseValid),
    .TagReleaseOut               (TagReleaseOut),
    .WritebackSourceOut          (WritebackSourceOut),
    .WritebackCongestionStallOut (WritebackCongestionStallOut)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int seq      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]    src;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic       en;
    logic [3:0] valid;
    logic       exp_rel;
    logic [1:0] exp_src;
    logic       exp_stall;
    logic [3:0] exp_ready;
  } vec_t;
  vec_t vecs[33];

  task automatic drive_auto(input logic [3:0] valid);
    SrcValid = valid;
    for (int i = 0; i < 4; i++) begin
      data_v[i] = 16'(seq * 4 + i) ^ 16'hA5C3;
      addr_v[i] = 4'(seq * 3 + i);
      tag_v[i]  = 6'(seq * 4 + i);
    end
    seq++;
  endtask

  // Records accepted results before the edge, then matches any release after it.
  task automatic edge_and_score(input string name);
    logic [3:0] acc;
    logic       en_at_edge;
    int         idx;
    sb_t        e;
    #1;
    en_at_edge = clk_en;
    acc = SrcValid & SrcReady & {4{clk_en}};
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        e.src = 2'(i); e.addr = addr_v[i]; e.data = data_v[i]; e.tag = tag_v[i];
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (en_at_edge) begin
      if (TagReleaseValid) begin
        idx = -1;
        for (int j = 0; j < sb_q.size(); j++) begin
          if (idx < 0 && sb_q[j].src == WritebackSourceOut) idx = j;
        end
        checks++;
        if (idx < 0) begin
          failures++;
          $display("FAIL %s_unexpected_release src=%0d tag=0x%0h expected=no_release",
                   name, WritebackSourceOut, TagReleaseOut);
        end else begin
          check($sformatf("%s_tag", name),  32'(TagReleaseOut), 32'(sb_q[idx].tag));
          check($sformatf("%s_addr", name), 32'(RegWriteAddr),  32'(sb_q[idx].addr));
          check($sformatf("%s_data", name), 32'(RegWriteData),  32'(sb_q[idx].data));
          check($sformatf("%s_we", name),   32'(RegWriteEn),
                32'(!(DISCARD && sb_q[idx].addr == '0)));
          sb_q.delete(idx);
        end
      end else begin
        check($sformatf("%s_idle_we", name), 32'(RegWriteEn), 32'(0));
      end
    end
  endtask

  initial begin
    //        en  valid    rel src stall ready
    vecs[0]  = '{1, 4'b1111, 0, 0, 1, 4'b1111};
    vecs[1]  = '{1, 4'b0000, 1, 0, 1, 4'b1111};
    vecs[2]  = '{1, 4'b0000, 1, 1, 1, 4'b1111};
    vecs[3]  = '{1, 4'b0000, 1, 2, 1, 4'b1111};
    vecs[4]  = '{1, 4'b0000, 1, 3, 0, 4'b1111};
    vecs[5]  = '{1, 4'b0000, 0, 0, 0, 4'b1111};
    vecs[6]  = '{1, 4'b0010, 0, 0, 1, 4'b1111};
    vecs[7]  = '{1, 4'b0000, 1, 1, 0, 4'b1111};
    vecs[8]  = '{1, 4'b1101, 0, 0, 1, 4'b1111};
    vecs[9]  = '{1, 4'b0000, 1, 2, 1, 4'b1111};
    vecs[10] = '{1, 4'b0000, 1, 3, 1, 4'b1111};
    vecs[11] = '{1, 4'b0000, 1, 0, 0, 4'b1111};
    vecs[12] = '{1, 4'b0000, 0, 0, 0, 4'b1111};
    vecs[13] = '{1, 4'b1111, 0, 0, 1, 4'b1111};
    vecs[14] = '{1, 4'b1111, 1, 1, 1, 4'b0010};
    vecs[15] = '{1, 4'b1111, 1, 2, 1, 4'b0100};
    vecs[16] = '{1, 4'b1111, 1, 3, 1, 4'b1000};
    vecs[17] = '{1, 4'b1111, 1, 0, 1, 4'b0001};
    vecs[18] = '{1, 4'b0000, 1, 1, 1, 4'b0011};
    vecs[19] = '{1, 4'b0000, 1, 2, 1, 4'b0111};
    vecs[20] = '{1, 4'b0000, 1, 3, 1, 4'b1111};
    vecs[21] = '{1, 4'b0000, 1, 0, 1, 4'b1111};
    vecs[22] = '{1, 4'b0000, 1, 1, 1, 4'b1111};
    vecs[23] = '{1, 4'b0000, 1, 2, 1, 4'b1111};
    vecs[24] = '{1, 4'b0000, 1, 3, 0, 4'b1111};
    vecs[25] = '{1, 4'b0000, 0, 0, 0, 4'b1111};
    vecs[26] = '{1, 4'b0001, 0, 0, 1, 4'b1111};
    vecs[27] = '{1, 4'b0100, 1, 0, 1, 4'b1111};
    vecs[28] = '{0, 4'b1111, 1, 0, 1, 4'b0000};
    vecs[29] = '{0, 4'b1111, 1, 0, 1, 4'b0000};
    vecs[30] = '{0, 4'b1111, 1, 0, 1, 4'b0000};
    vecs[31] = '{1, 4'b0000, 1, 2, 0, 4'b1111};
    vecs[32] = '{1, 4'b0000, 0, 0, 0, 4'b1111};

    sync_rst = 1'b1;
    clk_en   = 1'b1;
    drive_auto(4'b0000);
    #1;
    check("rst_we",    32'(RegWriteEn), 32'(0));
    check("rst_rel",   32'(TagReleaseValid), 32'(0));
    check("rst_addr",  32'(RegWriteAddr), 32'(0));
    check("rst_data",  32'(RegWriteData), 32'(0));
    check("rst_tag",   32'(TagReleaseOut), 32'(0));
    check("rst_src",   32'(WritebackSourceOut), 32'(0));
    check("rst_stall", 32'(WritebackCongestionStallOut), 32'(0));
    check("rst_ready", 32'(SrcReady), 32'(4'b1111));
    @(posedge clk);
    @(posedge clk);
    #1 sync_rst = 1'b0;

    for (int v = 0; v < 33; v++) begin
      clk_en = vecs[v].en;
      drive_auto(vecs[v].valid);
      edge_and_score($sformatf("vec%0d", v));
      check($sformatf("vec%0d_rel", v),   32'(TagReleaseValid), 32'(vecs[v].exp_rel));
      check($sformatf("vec%0d_stall", v), 32'(WritebackCongestionStallOut), 32'(vecs[v].exp_stall));
      check($sformatf("vec%0d_ready", v), 32'(SrcReady), 32'(vecs[v].exp_ready));
      if (vecs[v].exp_rel) begin
        check($sformatf("vec%0d_src", v), 32'(WritebackSourceOut), 32'(vecs[v].exp_src));
      end
    end

    // Single result on source 1: visible for exactly one cycle, two edges after valid.
    clk_en = 1'b1;
    SrcValid  = 4'b0010;
    data_v[1] = 16'hBEEF;
    addr_v[1] = 4'd5;
    tag_v[1]  = 6'h12;
    edge_and_score("single_acc");
    check("single_early_we", 32'(RegWriteEn), 32'(0));
    SrcValid = 4'b0000;
    edge_and_score("single_wr");
    check("single_we",   32'(RegWriteEn), 32'(1));
    check("single_addr", 32'(RegWriteAddr), 32'(5));
    check("single_data", 32'(RegWriteData), 32'(16'hBEEF));
    check("single_tag",  32'(TagReleaseOut), 32'(6'h12));
    check("single_src",  32'(WritebackSourceOut), 32'(1));
    edge_and_score("single_after");
    check("single_after_we", 32'(RegWriteEn), 32'(0));

    // Register 0 destination: tag always released, write strobe depends on build option.
    SrcValid  = 4'b1000;
    data_v[3] = 16'h1234;
    addr_v[3] = 4'd0;
    tag_v[3]  = 6'h07;
    edge_and_score("zero_acc");
    SrcValid = 4'b0000;
    edge_and_score("zero_wr");
    check("zero_rel", 32'(TagReleaseValid), 32'(1));
    check("zero_tag", 32'(TagReleaseOut), 32'(6'h07));
    check("zero_src", 32'(WritebackSourceOut), 32'(3));
    check("zero_we",  32'(RegWriteEn), 32'(!DISCARD));
    edge_and_score("zero_after");

    // Reset with three entries still buffered after one grant.
    drive_auto(4'b1111);
    edge_and_score("prerst_fill");
    drive_auto(4'b0000);
    edge_and_score("prerst_grant");
    check("prerst_rel", 32'(TagReleaseValid), 32'(1));
    #2 sync_rst = 1'b1;
    #1;
    check("midrst_we",    32'(RegWriteEn), 32'(0));
    check("midrst_rel",   32'(TagReleaseValid), 32'(0));
    check("midrst_addr",  32'(RegWriteAddr), 32'(0));
    check("midrst_data",  32'(RegWriteData), 32'(0));
    check("midrst_tag",   32'(TagReleaseOut), 32'(0));
    check("midrst_src",   32'(WritebackSourceOut), 32'(0));
    check("midrst_stall", 32'(WritebackCongestionStallOut), 32'(0));
    sb_q.delete();
    @(posedge clk);
    #1 sync_rst = 1'b0;
    check("postrst_ready", 32'(SrcReady), 32'(4'b1111));
    for (int n = 0; n < 4; n++) begin
      drive_auto(4'b0000);
      edge_and_score("postrst");
      check($sformatf("postrst%0d_rel", n), 32'(TagReleaseValid), 32'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
